glitch_sequencer: RTL and testbench



---
 rtl/glitch_sequencer_if.sv | 38 +++
 rtl/glitch_sequencer.sv | 145 ++++++++++++++
 tb/tb_glitch_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/glitch_sequencer_if.sv
// glitch_sequencer_if: control, trigger and status bundle between the UART register block and the glitch sequencer.
// glitch_total exists only when GLITCH_SEQ_STATS_EN is defined.
interface glitch_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int RPT_W = 8,
    parameter int N_CH  = 2
);
    logic [N_CH*CNT_W-1:0] cfg_delay;
    logic [N_CH*CNT_W-1:0] cfg_width;
    logic [N_CH*CNT_W-1:0] cfg_gap;
    logic [N_CH*RPT_W-1:0] cfg_repeat;
    logic [N_CH-1:0]       arm;
    logic [N_CH-1:0]       abort;
    logic [N_CH-1:0]       trigger;
    logic [N_CH-1:0]       glitch_en;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       armed;
    logic [N_CH-1:0]       done;
`ifdef GLITCH_SEQ_STATS_EN
    logic [N_CH*32-1:0]    glitch_total;
`endif

    modport master (
        output cfg_delay, cfg_width, cfg_gap, cfg_repeat, arm, abort, trigger,
`ifdef GLITCH_SEQ_STATS_EN
        input  glitch_total,
`endif
        input  glitch_en, busy, armed, done
    );

    modport slave (
        input  cfg_delay, cfg_width, cfg_gap, cfg_repeat, arm, abort, trigger,
`ifdef GLITCH_SEQ_STATS_EN
        output glitch_total,
`endif
        output glitch_en, busy, armed, done
    );
endinterface

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: per-channel armed, trigger-fired train of glitch gate pulses (delay, width, gap, repeat).
// Defining GLITCH_SEQ_STATS_EN adds a saturating per-channel pulse counter on glitch_total.
module glitch_sequencer #(
    parameter int CNT_W = 16,
    parameter int RPT_W = 8,
    parameter int N_CH  = 2
) (
    input logic               clk,
    input logic               reset,
    glitch_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARMED = 3'd1;
    localparam logic [2:0] DELAY = 3'd2;
    localparam logic [2:0] PULSE = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [N_CH-1:0]  s1_q, s2_q, dl_q, rise;
    logic [2:0]       st_q [N_CH];
    logic [2:0]       st_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] dly_q [N_CH];
    logic [CNT_W-1:0] dly_d [N_CH];
    logic [CNT_W-1:0] wid_q [N_CH];
    logic [CNT_W-1:0] wid_d [N_CH];
    logic [CNT_W-1:0] gap_q [N_CH];
    logic [CNT_W-1:0] gap_d [N_CH];
    logic [RPT_W-1:0] rem_q [N_CH];
    logic [RPT_W-1:0] rem_d [N_CH];
    logic [N_CH-1:0]  en_q, en_d, busy_q, busy_d, armed_q, armed_d, done_q, done_d;

    function automatic logic [CNT_W-1:0] nz_c(input logic [CNT_W-1:0] x);
        return x == '0 ? CNT_W'(1) : x;
    endfunction

    function automatic logic [RPT_W-1:0] nz_r(input logic [RPT_W-1:0] x);
        return x == '0 ? RPT_W'(1) : x;
    endfunction

    assign rise = s2_q & ~dl_q;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            st_d[k]  = st_q[k];
            cnt_d[k] = cnt_q[k];
            dly_d[k] = dly_q[k];
            wid_d[k] = wid_q[k];
            gap_d[k] = gap_q[k];
            rem_d[k] = rem_q[k];
            case (st_q[k])
                IDLE: if (bus.arm[k]) begin
                    dly_d[k] = bus.cfg_delay[k*CNT_W +: CNT_W];
                    wid_d[k] = nz_c(bus.cfg_width[k*CNT_W +: CNT_W]);
                    gap_d[k] = nz_c(bus.cfg_gap[k*CNT_W +: CNT_W]);
                    rem_d[k] = nz_r(bus.cfg_repeat[k*RPT_W +: RPT_W]);
                    st_d[k]  = ARMED;
                end
                ARMED: if (rise[k]) begin
                    st_d[k]  = dly_q[k] == '0 ? PULSE : DELAY;
                    cnt_d[k] = dly_q[k] == '0 ? wid_q[k] : dly_q[k];
                end
                DELAY: begin
                    st_d[k]  = cnt_q[k] == CNT_W'(1) ? PULSE : DELAY;
                    cnt_d[k] = cnt_q[k] == CNT_W'(1) ? wid_q[k] : cnt_q[k] - CNT_W'(1);
                end
                PULSE: if (cnt_q[k] == CNT_W'(1)) begin
                    st_d[k]  = rem_q[k] > RPT_W'(1) ? GAP : DONE;
                    cnt_d[k] = gap_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
                GAP: if (cnt_q[k] == CNT_W'(1)) begin
                    st_d[k]  = PULSE;
                    cnt_d[k] = wid_q[k];
                    rem_d[k] = rem_q[k] - RPT_W'(1);
                end else begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
                default: st_d[k] = IDLE;
            endcase
            // abort outranks everything, including a same-cycle arm
            if (bus.abort[k]) st_d[k] = IDLE;
            en_d[k]    = st_d[k] == PULSE;
            busy_d[k]  = st_d[k] == DELAY || st_d[k] == PULSE || st_d[k] == GAP;
            armed_d[k] = st_d[k] == ARMED;
            done_d[k]  = st_d[k] == DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            dl_q    <= '0;
            en_q    <= '0;
            busy_q  <= '0;
            armed_q <= '0;
            done_q  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                st_q[k]  <= IDLE;
                cnt_q[k] <= '0;
                dly_q[k] <= '0;
                wid_q[k] <= '0;
                gap_q[k] <= '0;
                rem_q[k] <= '0;
            end
        end else begin
            s1_q    <= bus.trigger;
            s2_q    <= s1_q;
            dl_q    <= s2_q;
            en_q    <= en_d;
            busy_q  <= busy_d;
            armed_q <= armed_d;
            done_q  <= done_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            wid_q   <= wid_d;
            gap_q   <= gap_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.glitch_en = en_q;
    assign bus.busy      = busy_q;
    assign bus.armed     = armed_q;
    assign bus.done      = done_q;

`ifdef GLITCH_SEQ_STATS_EN
    logic [N_CH*32-1:0] tot_q, tot_d;

    always_comb begin
        tot_d = tot_q;
        for (int k = 0; k < N_CH; k++)
            if (en_d[k] && !en_q[k] && tot_q[k*32 +: 32] != '1)
                tot_d[k*32 +: 32] = tot_q[k*32 +: 32] + 32'd1;
    end

    always_ff @(posedge clk) tot_q <= !reset ? '0 : tot_d;

    assign bus.glitch_total = tot_q;
`endif
endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: directed trains; expected gate edges and done pulses are queued per channel and matched by a monitor.
// Event codes pushed into the queues are edge*4 + kind (0 gate rise, 1 gate fall, 2 done).
module tb_glitch_sequencer;
    localparam int CW = 8;
    localparam int RW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;
    logic [1:0] pen = '0;
    int   q0[$];
    int   q1[$];

    glitch_sequencer_if #(.CNT_W(CW), .RPT_W(RW), .N_CH(2)) bus ();

    glitch_sequencer #(.CNT_W(CW), .RPT_W(RW), .N_CH(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c, input int v);
        if (c == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    task automatic see(input int c, input int kind);
        int v;
        n_chk++;
        if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
            n_fail++;
            $display("FAIL ch%0d event: got kind %0d at edge %0d, expected none", c, kind, cyc);
            return;
        end
        if (c == 0) v = q0.pop_front();
        else v = q1.pop_front();
        if (v != cyc * 4 + kind) begin
            n_fail++;
            $display("FAIL ch%0d event: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                     c, kind, cyc, v % 4, v / 4);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && reset)
            for (int c = 0; c < 2; c++) begin
                if (bus.glitch_en[c] && !pen[c]) see(c, 0);
                if (!bus.glitch_en[c] && pen[c]) see(c, 1);
                if (bus.done[c]) see(c, 2);
            end
        pen = bus.glitch_en;
    end

    task automatic arm_ch(input int c, input int d, input int w, input int g, input int r);
        bus.cfg_delay[c*CW +: CW]  = CW'(d);
        bus.cfg_width[c*CW +: CW]  = CW'(w);
        bus.cfg_gap[c*CW +: CW]    = CW'(g);
        bus.cfg_repeat[c*RW +: RW] = RW'(r);
        bus.arm[c] = 1'b1;
        step(1);
        bus.arm[c] = 1'b0;
    endtask

    // Raise the trigger; the next rising edge is E0. Queues np pulses and optionally the done pulse.
    task automatic fire(input int c, input int d, input int w, input int g, input int r,
                        input int np, input bit dn);
        int e0, w1, g1, r1, t;
        bus.trigger[c] = 1'b1;
        e0 = cyc + 1;
        w1 = w == 0 ? 1 : w;
        g1 = g == 0 ? 1 : g;
        r1 = r == 0 ? 1 : r;
        for (int k = 0; k < np; k++) begin
            t = e0 + 2 + d + k * (w1 + g1);
            push(c, t * 4);
            push(c, (t + w1) * 4 + 1);
        end
        if (dn) push(c, (e0 + 2 + d + r1 * w1 + (r1 - 1) * g1) * 4 + 2);
    endtask

    initial begin
        bus.cfg_delay = '0;
        bus.cfg_width = '0;
        bus.cfg_gap = '0;
        bus.cfg_repeat = '0;
        bus.arm = '0;
        bus.abort = '0;
        bus.trigger = '0;
        step(3);
        check("reset glitch_en", 32'(bus.glitch_en), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset armed", 32'(bus.armed), 0);
        check("reset done", 32'(bus.done), 0);
        reset = 1'b1;
        step(2);

        arm_ch(0, 5, 3, 4, 3);
        check("arm ch0", 32'(bus.armed), 1);
        bus.cfg_delay[CW-1:0] = 8'd1;
        bus.cfg_width[CW-1:0] = 8'd9;
        fire(0, 5, 3, 4, 3, 3, 1'b1);
        step(30);
        check("ch0 idle after train", 32'(bus.armed | bus.busy), 0);
        bus.trigger[0] = 1'b0;
        step(3);

        arm_ch(0, 0, 0, 0, 0);
        fire(0, 0, 0, 0, 0, 1, 1'b1);
        step(8);
        bus.trigger[0] = 1'b0;
        step(2);

        arm_ch(0, 2, 2, 3, 10);
        fire(0, 2, 2, 3, 10, 2, 1'b0);
        step(12);
        check("ch0 busy in 2nd gap", 32'(bus.busy[0]), 1);
        bus.abort[0] = 1'b1;
        step(1);
        check("abort busy", 32'(bus.busy[0]), 0);
        check("abort glitch_en", 32'(bus.glitch_en[0]), 0);
        bus.abort[0] = 1'b0;
        step(10);
        arm_ch(0, 1, 1, 1, 1);
        check("re-arm after abort", 32'(bus.armed[0]), 1);
        bus.trigger[0] = 1'b0;

        bus.abort[0] = 1'b1;
        step(1);
        bus.abort[0] = 1'b0;
        check("abort from armed", 32'(bus.armed[0]), 0);
        bus.trigger[0] = 1'b1;
        step(4);
        arm_ch(0, 1, 2, 1, 2);
        step(6);
        check("held trigger no fire", 32'(bus.armed[0]), 1);
        bus.trigger[0] = 1'b0;
        step(2);
        fire(0, 1, 2, 1, 2, 2, 1'b1);
        step(2);
        bus.trigger[0] = 1'b0;
        step(2);
        bus.trigger[0] = 1'b1;
        arm_ch(0, 0, 5, 5, 5);
        step(10);
        check("no retrigger or re-arm", 32'(bus.armed[0]), 0);
        bus.trigger[0] = 1'b0;
        step(2);

        arm_ch(0, 3, 2, 2, 2);
        arm_ch(1, 1, 4, 1, 3);
        fire(0, 3, 2, 2, 2, 2, 1'b1);
        step(3);
        fire(1, 1, 4, 1, 3, 3, 1'b1);
        step(30);
        bus.trigger = '0;
        step(2);

        arm_ch(1, 255, 1, 1, 1);
        fire(1, 255, 1, 1, 1, 1, 1'b1);
        step(262);
        bus.trigger[1] = 1'b0;
        step(2);

        mon_en = 1'b0;
        arm_ch(0, 1, 4, 1, 3);
        arm_ch(1, 0, 3, 2, 2);
        bus.trigger = 2'b11;
        step(5);
        check("both pulsing pre-reset", 32'(bus.glitch_en), 3);
        reset = 1'b0;
        step(1);
        check("mid-train reset glitch_en", 32'(bus.glitch_en), 0);
        check("mid-train reset busy", 32'(bus.busy), 0);
        check("mid-train reset armed", 32'(bus.armed), 0);
        check("mid-train reset done", 32'(bus.done), 0);
        step(2);
        reset = 1'b1;
        bus.trigger = '0;
        step(3);
        mon_en = 1'b1;

        arm_ch(0, 0, 1, 1, 3);
        fire(0, 0, 1, 1, 3, 3, 1'b1);
        step(12);
        bus.trigger[0] = 1'b0;
        step(2);
        arm_ch(0, 0, 1, 1, 5);
        fire(0, 0, 1, 1, 5, 5, 1'b1);
        step(15);
        bus.trigger[0] = 1'b0;
`ifdef GLITCH_SEQ_STATS_EN
        check("glitch_total ch0", int'(bus.glitch_total[31:0]), 8);
`endif
        step(3);
        check("ch0 events outstanding", q0.size(), 0);
        check("ch1 events outstanding", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
